// File: rtl/multicycle_core_if.sv
// multicycle_core_if -- unified instruction/data memory bus of multicycle_core.
//   master : the core (drives mem_req, mem_we, mem_addr, mem_wdata)
//   slave  : the memory (drives mem_rdata, mem_ready)
// An access completes in any cycle where mem_req and mem_ready are both high;
// mem_rdata is valid in that cycle.
interface multicycle_core_if #(
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/multicycle_core.sv
// multicycle_core -- multicycle RV32I/RV32E subset core on one memory port.
// Instructions: add sub and or slt addi andi ori slti lw sw beq bne jal jalr lui.
// Ports:
//   clk     sole clock, rising edge
//   reset   synchronous, active-high
//   bus     multicycle_core_if.master (mem_req/mem_we/mem_addr/mem_wdata out,
//           mem_rdata/mem_ready in)
//   retire  one-cycle pulse in the final cycle of each instruction
//   halted  high while stopped on an illegal instruction
// Build option MULTICYCLE_ILLEGAL_HALT_EN: illegal instructions stop the core
// in HALT until reset. Undefined (default): they retire as a NOP.
//
// state  | meaning
// FETCH  | read instruction at PC, PC += 4
// DECODE | read A/B, ALUOUT = OLDPC + imm_B (branch target)
// EXEC_R | ALUOUT = A op B
// EXEC_I | ALUOUT = A op imm_I
// MEMADR | ALUOUT = A + imm_I/imm_S
// MEMRD  | load from ALUOUT into MDR
// MEMWR  | store B to ALUOUT, retires on completion
// ALUWB  | rd = ALUOUT
// MEMWB  | rd = MDR
// BRANCH | PC = ALUOUT when condition holds
// JAL    | rd = OLDPC + 4, PC = OLDPC + imm_J
// JALR   | rd = OLDPC + 4, PC = (A + imm_I) & ~3
// LUI    | rd = imm_U
// HALT   | stopped, no requests
module multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32,
  parameter int          DATA_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_core_if.master   bus,
  output logic                retire,
  output logic                halted
);
  localparam int RW = $clog2(NUM_REGS);

  localparam logic [3:0] FETCH  = 4'd0,  DECODE = 4'd1,  EXEC_R = 4'd2,
                         EXEC_I = 4'd3,  MEMADR = 4'd4,  MEMRD  = 4'd5,
                         MEMWR  = 4'd6,  ALUWB  = 4'd7,  MEMWB  = 4'd8,
                         BRANCH = 4'd9,  JAL    = 4'd10, JALR   = 4'd11,
                         LUI    = 4'd12, HALT   = 4'd13;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I   = 7'b0010011,
                         OP_LW = 7'b0000011, OP_SW = 7'b0100011,
                         OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;

  logic [3:0]        state;
  logic [DATA_W-1:0] pc, oldpc, ir, a, b, aluout, mdr;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [6:0] opcode, funct7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic [DATA_W-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [DATA_W-1:0] rs1_val, rs2_val;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};

  assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1[RW-1:0]];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2[RW-1:0]];

  function automatic logic [DATA_W-1:0] alu(input logic [DATA_W-1:0] x,
                                            input logic [DATA_W-1:0] y,
                                            input logic [2:0]        f,
                                            input logic              sub);
    case (f)
      3'b000:  return sub ? x - y : x + y;
      3'b111:  return x & y;
      3'b110:  return x | y;
      3'b010:  return {{(DATA_W-1){1'b0}}, $signed(x) < $signed(y)};
      default: return x + y;
    endcase
  endfunction

  // Decode: legality and first post-DECODE state. Register-field checks only
  // look at the fields the instruction format actually carries.
  logic       legal, use_rd, use_rs1, use_rs2;
  logic [3:0] dec_state;

  always_comb begin
    legal     = 1'b0;
    use_rd    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    dec_state = FETCH;
    case (opcode)
      OP_R: begin
        legal = (funct7 == 7'h00 && (funct3 == 3'b000 || funct3 == 3'b111 ||
                                     funct3 == 3'b110 || funct3 == 3'b010)) ||
                (funct7 == 7'h20 && funct3 == 3'b000);
        {use_rd, use_rs1, use_rs2} = 3'b111;
        dec_state = EXEC_R;
      end
      OP_I: begin
        legal = (funct3 == 3'b000 || funct3 == 3'b111 ||
                 funct3 == 3'b110 || funct3 == 3'b010);
        {use_rd, use_rs1} = 2'b11;
        dec_state = EXEC_I;
      end
      OP_LW: begin
        legal = (funct3 == 3'b010);
        {use_rd, use_rs1} = 2'b11;
        dec_state = MEMADR;
      end
      OP_SW: begin
        legal = (funct3 == 3'b010);
        {use_rs1, use_rs2} = 2'b11;
        dec_state = MEMADR;
      end
      OP_BR: begin
        legal = (funct3 == 3'b000 || funct3 == 3'b001);
        {use_rs1, use_rs2} = 2'b11;
        dec_state = BRANCH;
      end
      OP_JAL: begin
        legal     = 1'b1;
        use_rd    = 1'b1;
        dec_state = JAL;
      end
      OP_JALR: begin
        legal = (funct3 == 3'b000);
        {use_rd, use_rs1} = 2'b11;
        dec_state = JALR;
      end
      OP_LUI: begin
        legal     = 1'b1;
        use_rd    = 1'b1;
        dec_state = LUI;
      end
      default: legal = 1'b0;
    endcase
    if (NUM_REGS == 16 && ((use_rd && rd[4]) || (use_rs1 && rs1[4]) ||
                           (use_rs2 && rs2[4])))
      legal = 1'b0;
  end

  // Register-file write port, active only in write-back style states.
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;

  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = '0;
    case (state)
      ALUWB:     begin rf_we = 1'b1; rf_wdata = aluout;      end
      MEMWB:     begin rf_we = 1'b1; rf_wdata = mdr;         end
      JAL, JALR: begin rf_we = 1'b1; rf_wdata = oldpc + 4;   end
      LUI:       begin rf_we = 1'b1; rf_wdata = imm_u;       end
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (rf_we && rd != 5'd0) begin
      regs[rd[RW-1:0]] <= rf_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      oldpc  <= '0;
      ir     <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
      mdr    <= '0;
    end else begin
      case (state)
        FETCH: if (bus.mem_ready) begin
          ir    <= bus.mem_rdata;
          oldpc <= pc;
          pc    <= pc + 4;
          state <= DECODE;
        end
        DECODE: begin
          a      <= rs1_val;
          b      <= rs2_val;
          aluout <= oldpc + imm_b;
`ifdef MULTICYCLE_ILLEGAL_HALT_EN
          state  <= legal ? dec_state : HALT;
`else
          state  <= legal ? dec_state : FETCH;
`endif
        end
        EXEC_R: begin
          aluout <= alu(a, b, funct3, funct7[5]);
          state  <= ALUWB;
        end
        EXEC_I: begin
          aluout <= alu(a, imm_i, funct3, 1'b0);
          state  <= ALUWB;
        end
        MEMADR: begin
          aluout <= a + ((opcode == OP_SW) ? imm_s : imm_i);
          state  <= (opcode == OP_SW) ? MEMWR : MEMRD;
        end
        MEMRD: if (bus.mem_ready) begin
          mdr   <= bus.mem_rdata;
          state <= MEMWB;
        end
        MEMWR: if (bus.mem_ready) state <= FETCH;
        BRANCH: begin
          if (funct3[0] ? (a != b) : (a == b)) pc <= aluout;
          state <= FETCH;
        end
        JAL: begin
          pc    <= oldpc + imm_j;
          state <= FETCH;
        end
        JALR: begin
          pc    <= (a + imm_i) & ~32'd3;
          state <= FETCH;
        end
        ALUWB, MEMWB, LUI: state <= FETCH;
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // Outputs are gated by reset so the reset cycle itself shows no request
  // and no retire regardless of the state being abandoned.
  logic nop_retire;
`ifdef MULTICYCLE_ILLEGAL_HALT_EN
  assign nop_retire = 1'b0;
  assign halted     = !reset && (state == HALT);
`else
  assign nop_retire = (state == DECODE) && !legal;
  assign halted     = 1'b0;
`endif

  assign bus.mem_req   = !reset && (state == FETCH || state == MEMRD || state == MEMWR);
  assign bus.mem_we    = !reset && (state == MEMWR);
  assign bus.mem_addr  = (state == FETCH) ? pc : aluout;
  assign bus.mem_wdata = b;

  assign retire = !reset && (state == ALUWB || state == MEMWB || state == BRANCH ||
                             state == JAL || state == JALR || state == LUI ||
                             (state == MEMWR && bus.mem_ready) || nop_retire);
endmodule

// File: tb/tb_multicycle_core.sv
// Testbench for multicycle_core: directed scenarios, randomized instruction
// stream with random memory wait states, checked against an ISA-level model.
module tb_multicycle_core;
  logic clk = 1'b0;
  logic reset;
  logic retire, halted;

  multicycle_core_if #(.DATA_W(32)) bus ();

  multicycle_core #(.RESET_PC(32'h0), .NUM_REGS(32), .DATA_W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .retire (retire),
    .halted (halted)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_pc;
  logic [31:0] m_x [32];
  logic [31:0] dmem [64];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] off, input logic [4:0] rd);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [4:0]  rd, rs1, rs2;
    int t;
    r   = $urandom;
    t   = $urandom_range(0, 17);
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    case (t)
      0:  return enc_r(7'h00, rs2, rs1, 3'b000, rd);
      1:  return enc_r(7'h20, rs2, rs1, 3'b000, rd);
      2:  return enc_r(7'h00, rs2, rs1, 3'b111, rd);
      3:  return enc_r(7'h00, rs2, rs1, 3'b110, rd);
      4:  return enc_r(7'h00, rs2, rs1, 3'b010, rd);
      5:  return enc_i(r[11:0], rs1, 3'b000, rd, 7'h13);
      6:  return enc_i(r[11:0], rs1, 3'b111, rd, 7'h13);
      7:  return enc_i(r[11:0], rs1, 3'b110, rd, 7'h13);
      8:  return enc_i(r[11:0], rs1, 3'b010, rd, 7'h13);
      9:  return enc_i(r[11:0], rs1, 3'b010, rd, 7'h03);
      10: return enc_s(r[11:0], rs2, rs1);
      11: return enc_b({r[11:0], 1'b0}, rs2, rs1, 3'b000);
      12: return enc_b({r[11:0], 1'b0}, rs2, rs1, 3'b001);
      13: return enc_j({r[31:12], 1'b0}, rd);
      14: return enc_i(r[11:0], rs1, 3'b000, rd, 7'h67);
      15: return {r[31:12], rd, 7'h37};
      16: return {r[31:7], 7'h7f};
      default: return enc_r(7'h01, rs2, rs1, 3'b000, rd);
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) begin
      @(negedge clk); #1;
      check_eq("rst_req", bus.mem_req, 0);
      check_eq("rst_retire", retire, 0);
      check_eq("rst_halted", halted, 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_x[i] = '0;
  endtask

  // Executes one instruction on the model, then serves the DUT bus with the
  // given wait counts (fw for the fetch, dw for the data access) and checks
  // every access, the retire cycle and the total latency.
  task automatic run_instr(input logic [31:0] instr, input int fw, input int dw);
    logic [6:0]  op, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, va, vb, res, daddr, wdat, npc, exp_addr;
    bit legal, wr, done, hlt, rdy;
    int kind, base, n_acc, cyc, waits, acc, wleft;
    op = instr[6:0]; rd = instr[11:7]; f3 = instr[14:12];
    rs1 = instr[19:15]; rs2 = instr[24:20]; f7 = instr[31:25];
    imm_i = $signed(instr) >>> 20;
    imm_s = {imm_i[31:5], instr[11:7]};
    imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    va = m_x[rs1]; vb = m_x[rs2];
    legal = 0; kind = 8; res = 0; daddr = 0; wdat = 0; npc = m_pc + 4;
    case (op)
      7'h33, 7'h13: begin
        logic [31:0] y;
        kind = (op == 7'h33) ? 0 : 1;
        y = (op == 7'h33) ? vb : imm_i;
        if (op == 7'h13 || f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'b000)) begin
          legal = 1;
          case (f3)
            3'b000: res = (op == 7'h33 && f7 == 7'h20) ? va - y : va + y;
            3'b111: res = va & y;
            3'b110: res = va | y;
            3'b010: res = ($signed(va) < $signed(y)) ? 32'd1 : 32'd0;
            default: legal = 0;
          endcase
        end
      end
      7'h03: if (f3 == 3'b010) begin
        legal = 1; kind = 2; daddr = va + imm_i; res = dmem[daddr[7:2]];
      end
      7'h23: if (f3 == 3'b010) begin
        legal = 1; kind = 3; daddr = va + imm_s; wdat = vb;
      end
      7'h63: if (f3 == 3'b000 || f3 == 3'b001) begin
        legal = 1; kind = 4;
        if ((f3 == 3'b001) ? (va != vb) : (va == vb)) npc = m_pc + imm_b;
      end
      7'h6f: begin legal = 1; kind = 5; res = m_pc + 4; npc = m_pc + imm_j; end
      7'h67: if (f3 == 3'b000) begin
        legal = 1; kind = 6; res = m_pc + 4; npc = (va + imm_i) & 32'hFFFF_FFFC;
      end
      7'h37: begin legal = 1; kind = 7; res = {instr[31:12], 12'h000}; end
      default: legal = 0;
    endcase
    if (!legal) kind = 8;
    wr = (kind == 0 || kind == 1 || kind == 2 || kind == 5 || kind == 6 || kind == 7);
    case (kind)
      0, 1, 3: base = 4;
      2:       base = 5;
      8:       base = 2;
      default: base = 3;
    endcase
    n_acc = (kind == 2 || kind == 3) ? 2 : 1;

    cyc = 0; waits = 0; acc = 0; wleft = fw; done = 0; hlt = 0;
    while (!done && !hlt && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_req) begin
        rdy = (wleft == 0);
        if (!rdy) wleft--;
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      bus.mem_ready = rdy;
      bus.mem_rdata = (acc == 0) ? instr : dmem[bus.mem_addr[7:2]];
      #1;
      if (bus.mem_req) begin
        if (acc >= n_acc) begin
          check_eq("extra_req", bus.mem_req, 0);
        end else begin
          exp_addr = (acc == 0) ? m_pc : daddr;
          check_eq("addr", bus.mem_addr, exp_addr);
          check_eq("we", bus.mem_we, (acc == 1 && kind == 3) ? 1 : 0);
          if (acc == 1 && kind == 3) check_eq("wdata", bus.mem_wdata, wdat);
          if (rdy) begin acc++; wleft = dw; end
        end
        if (!rdy) waits++;
      end
      done = retire;
      hlt  = halted;
    end

`ifdef MULTICYCLE_ILLEGAL_HALT_EN
    if (!legal) begin
      check_eq("halted", hlt, 1);
      repeat (10) begin
        @(negedge clk); #1;
        check_eq("halt_req", bus.mem_req, 0);
        check_eq("halt_hold", halted, 1);
      end
      do_reset();
      return;
    end
`endif
    check_eq("retired", done, 1);
    check_eq("halted_low", hlt, 0);
    check_eq("latency", cyc, base + waits);
    check_eq("accesses", acc, n_acc);

    if (kind == 3) dmem[daddr[7:2]] = wdat;
    if (wr && rd != 5'd0) m_x[rd] = res;
    m_pc = npc;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) dmem[i] = $urandom;
    do_reset();

    // addi x1,x0,5 ; sw x1,8(x0) with a 3-cycle data stall
    run_instr(enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'h13), 0, 0);
    run_instr(enc_s(12'd8, 5'd1, 5'd0), 0, 3);
    // two NOPs to reach 0x10, then beq back to 0x0C and a not-taken bne
    run_instr(32'h0000_0013, 0, 0);
    run_instr(32'h0000_0013, 0, 0);
    run_instr(enc_b(13'h1FFC, 5'd0, 5'd0, 3'b000), 0, 0);
    run_instr(enc_b(13'h1FFC, 5'd0, 5'd0, 3'b001), 0, 0);
    // addi x2,x0,0x100 ; jalr x1,3(x2) ; sw x1,0(x0) exposes the link value
    run_instr(enc_i(12'h100, 5'd0, 3'b000, 5'd2, 7'h13), 0, 0);
    run_instr(enc_i(12'd3, 5'd2, 3'b000, 5'd1, 7'h67), 0, 0);
    run_instr(enc_s(12'd0, 5'd1, 5'd0), 1, 2);
    // illegal opcode
    run_instr(32'h0000_007F, 0, 0);

    // reset while lw x5,0(x0) is stalled in its data read
    run_instr(enc_i(12'd77, 5'd0, 3'b000, 5'd5, 7'h13), 0, 0);
    @(negedge clk);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = enc_i(12'd0, 5'd0, 3'b010, 5'd5, 7'h03);
    #1 check_eq("lw_fetch_addr", bus.mem_addr, m_pc);
    @(negedge clk); bus.mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check_eq("lw_stall_req", bus.mem_req, 1);
    check_eq("lw_stall_addr", bus.mem_addr, 32'h0);
    @(negedge clk);
    do_reset();
    run_instr(enc_s(12'd0, 5'd5, 5'd0), 0, 0);

    repeat (300) run_instr(gen_instr(), $urandom_range(0, 2), $urandom_range(0, 2));

    for (int i = 1; i < 32; i++)
      run_instr(enc_s(12'(i * 4), 5'(i), 5'd0), 0, $urandom_range(0, 1));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/multicycle_core.md
MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 The block SHALL expose parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL expose parameter NUM_REGS, default 32, meaning the register count (32 = RV32I, 16 = RV32E), legal values 16 and 32 only.
REQ-003 The block SHALL expose parameter DATA_W, default 32, meaning the datapath, address and register width, legal value 32 only.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port mem_req  output  1  memory access request.
REQ-007 Port mem_we  output  1  write when high, read when low; qualified by mem_req.
REQ-008 Port mem_addr  output  DATA_W  byte address of the access.
REQ-009 Port mem_wdata  output  DATA_W  store data.
REQ-010 Port mem_rdata  input  DATA_W  read data, valid in the cycle mem_ready is high.
REQ-011 Port mem_ready  input  1  access completes in any cycle where mem_req and mem_ready are both high.
REQ-012 Port retire  output  1  one-cycle pulse when an instruction completes.
REQ-013 Port halted  output  1  high while the core is stopped on an illegal instruction.

Function
REQ-014 The block SHALL use one unified memory port for instructions and data, and SHALL hold the internal registers PC, OLDPC, IR, A, B, ALUOUT and MDR.
REQ-015 The block SHALL support these instructions: add, sub, and, or, slt, addi, andi, ori, slti, lw, sw, beq, bne, jal, jalr and lui.
REQ-016 The controller FSM SHALL have the states FETCH, DECODE, EXEC_R, EXEC_I, MEMADR, MEMRD, MEMWR, ALUWB, MEMWB, BRANCH, JAL, JALR, LUI and HALT.
REQ-017 FETCH behaviour:
  - mem_req=1, mem_we=0, mem_addr=PC.
  - Stay in FETCH while mem_ready=0; hold all outputs stable.
  - On ready: IR<=mem_rdata, OLDPC<=PC, PC<=PC+4, go to DECODE.
REQ-018 In DECODE the block SHALL load A and B from the register file and set ALUOUT<=OLDPC+imm_B, then branch on the opcode.
REQ-019 Next-state paths:
  - R-type: EXEC_R then ALUWB.
  - I-type ALU: EXEC_I then ALUWB.
  - lw: MEMADR, MEMRD, MEMWB.
  - sw: MEMADR, MEMWR.
  - beq/bne: BRANCH.
  - jal: JAL.
  - jalr: JALR.
  - lui: LUI.
  - Each path returns to FETCH.
REQ-020 In MEMRD and MEMWR the block SHALL drive mem_req=1 with mem_addr=ALUOUT, and SHALL wait for mem_ready. MEMWR drives mem_we=1 and mem_wdata=B. MEMRD latches MDR.
REQ-021 In BRANCH the block SHALL set PC<=ALUOUT when the condition holds (A==B for beq, A!=B for bne); otherwise PC is unchanged.
REQ-022 JAL SHALL write rd<=OLDPC+4 and PC<=OLDPC+imm_J.
REQ-023 JALR SHALL write rd<=OLDPC+4 and PC<=(A+imm_I) with bits [1:0] forced to 0.
REQ-024 LUI SHALL write rd<=imm_U.
REQ-025 Latency with zero-wait memory SHALL be:
  - 3 cycles: branch, jal, jalr, lui.
  - 4 cycles: R-type, I-type ALU, sw.
  - 5 cycles: lw.
  - Each wait cycle adds exactly 1 cycle.
REQ-026 retire SHALL pulse high in the final cycle of each instruction path (ALUWB, MEMWB, the completing MEMWR cycle, BRANCH, JAL, JALR, LUI).
REQ-027 Writes to x0 SHALL be discarded, and x0 SHALL always read as 0.
REQ-028 All PC and address arithmetic SHALL wrap modulo 2^DATA_W.
REQ-029 slt and slti SHALL compare signed; immediates SHALL be sign-extended as defined by RV32I.
REQ-030 With NUM_REGS=16, any rs1, rs2 or rd field of 16 or above SHALL be classed as an illegal instruction.
REQ-031 mem_req SHALL be 0 in every state except FETCH, MEMRD and MEMWR.

Reset
REQ-032 On reset the block SHALL set PC=RESET_PC, state=FETCH, mem_req=0 in that cycle, retire=0 and halted=0. IR, A, B, ALUOUT, MDR and OLDPC SHALL be cleared to 0.
REQ-033 Reset during a memory wait SHALL abandon the access with no register-file write; the first request after release SHALL fetch RESET_PC.
REQ-034 The register file contents SHALL be cleared to 0 on reset.

Configuration
REQ-035 With macro MULTICYCLE_ILLEGAL_HALT_EN defined, an unsupported opcode or funct (or the REQ-030 case) SHALL cause DECODE->HALT. HALT holds halted=1, mem_req=0 and PC=OLDPC+4 until reset.
REQ-036 Without the macro, such an instruction SHALL retire as a NOP (DECODE->FETCH with retire=1). halted SHALL be tied 0.

Verification
REQ-037 Scenario: reset, then zero-wait memory with addi x1,x0,5 at 0 -> retire in cycle 4, x1=5, PC=4.
REQ-038 Scenario: sw x1,8(x0) with mem_ready delayed 3 cycles -> mem_we=1, addr=8, wdata=5 held stable for 4 cycles, then a single retire.
REQ-039 Scenario: beq x0,x0,-4 at address 0x10 -> after 3 cycles PC=0x0C; the bne equivalent -> PC=0x14.
REQ-040 Scenario: jalr x1,3(x2) with x2=0x100 -> PC=0x100, x1=OLDPC+4.
REQ-041 Scenario: illegal opcode 7'h7F -> halted=1 and no further mem_req with the macro; NOP with retire and PC+4 without it.
REQ-042 Scenario: reset asserted during a stalled lw MEMRD -> rd unchanged, next fetch at RESET_PC.
